// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter.
package seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LW    = 4;
  localparam int DEF_RW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_generator.sv
// Serial pattern transmitter: sends bits [L-1:0] of a captured pattern
// MSB-first, repeated repeat_n extra times, then pulses done.
// The pattern is left-aligned at capture so the next bit is always the
// MSB of a shift register; this avoids indexing with a variable.
module seq_generator
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LW    = DEF_LW,
  parameter int RW    = DEF_RW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic [RW-1:0]    repeat_n,
  input  logic             abort,
  output logic             serial_out,
  output logic             valid_out,
  output logic             busy,
  output logic             done
);

  localparam logic [LW-1:0] WMAX = LW'(WIDTH);

  state_t           state, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;     // left-aligned copy for reloads
  logic [WIDTH-1:0] sreg, sreg_d;     // bits still to send this pass
  logic [LW-1:0]    idx, idx_d;       // bit index of the bit on the line
  logic [LW-1:0]    len_q, len_d;     // effective length captured at accept
  logic [RW-1:0]    rep, rep_d;       // passes still to go after this one
  logic             serial_d, valid_d, busy_d, done_d;

  logic [LW-1:0]    eff_len;
  logic [WIDTH-1:0] aligned;

  // Effective length: 0 or out-of-range lengths mean a full-width pattern.
  always_comb begin
    eff_len = len;
    if (len == '0 || len > WMAX) eff_len = WMAX;
    aligned = pattern << (WMAX - eff_len);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pat_q      <= '0;
      sreg       <= '0;
      idx        <= '0;
      len_q      <= '0;
      rep        <= '0;
      serial_out <= 1'b0;
      valid_out  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      pat_q      <= pat_d;
      sreg       <= sreg_d;
      idx        <= idx_d;
      len_q      <= len_d;
      rep        <= rep_d;
      serial_out <= serial_d;
      valid_out  <= valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next state and next output values; outputs default to idle zeros.
  always_comb begin
    state_d  = state;
    pat_d    = pat_q;
    sreg_d   = sreg;
    idx_d    = idx;
    len_d    = len_q;
    rep_d    = rep;
    serial_d = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          pat_d    = aligned;
          sreg_d   = aligned << 1;
          serial_d = aligned[WIDTH-1];
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          idx_d    = eff_len - LW'(1);
          len_d    = eff_len;
          rep_d    = repeat_n;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          // Bit on the line this cycle was valid; drop straight to idle.
          state_d = ST_IDLE;
        end else if (idx == '0) begin
          if (rep != '0) begin
            // Next pass starts with no gap.
            rep_d    = rep - RW'(1);
            idx_d    = len_q - LW'(1);
            serial_d = pat_q[WIDTH-1];
            sreg_d   = pat_q << 1;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          idx_d    = idx - LW'(1);
          serial_d = sreg[WIDTH-1];
          sreg_d   = sreg << 1;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
